// File: rtl/update_gather.sv
// Gather-phase consumer: pops {dst, val} updates and read-modify-writes the vertex memory.
// Define GATHER_SUM_EN to accumulate (wrapping add); the default build keeps the unsigned minimum.
module update_gather #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned UPD_W  = ADDR_W + DATA_W,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_updates,
    input  logic              fifo_empty,
    output logic              fifo_re,
    input  logic [UPD_W-1:0]  fifo_dout,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  changed_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GATHER = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_retired;
    logic [CNT_W-1:0]  r_changed;
    logic [DATA_W-1:0] r_host_rdata;

    logic              r_s1_vld;
    logic              r_s2_vld;
    logic [ADDR_W-1:0] r_s2_addr;
    logic [DATA_W-1:0] r_s2_val;
    logic [DATA_W-1:0] r_rd_data;

    logic              r_fwd_vld;
    logic [ADDR_W-1:0] r_fwd_addr;
    logic [DATA_W-1:0] r_fwd_data;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_fifo_re;
    logic [ADDR_W-1:0] w_s1_addr;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_new;
    logic              w_pipe_empty;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    assign w_fifo_re    = (r_state == S_GATHER) && !fifo_empty && (r_issued < r_count);
    assign w_s1_addr    = fifo_dout[UPD_W-1 -: ADDR_W];
    assign w_pipe_empty = !r_s1_vld && !r_s2_vld;

    // The memory read for this record raced the previous record's write; take the forwarded value.
    assign w_old = (r_fwd_vld && (r_fwd_addr == r_s2_addr)) ? r_fwd_data : r_rd_data;

`ifdef GATHER_SUM_EN
    assign w_new = w_old + r_s2_val;
`else
    assign w_new = (r_s2_val < w_old) ? r_s2_val : w_old;
`endif

    // Pipeline writeback owns the write port; host writes only land while idle.
    assign w_mem_we    = !rst && (r_s2_vld || ((r_state == S_IDLE) && host_we));
    assign w_mem_waddr = r_s2_vld ? r_s2_addr : host_addr;
    assign w_mem_wdata = r_s2_vld ? w_new : host_wdata;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_GATHER;
            S_GATHER: if ((r_retired == r_count) && w_pipe_empty) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_count      <= '0;
            r_issued     <= '0;
            r_retired    <= '0;
            r_changed    <= '0;
            r_host_rdata <= '0;
            r_s1_vld     <= 1'b0;
            r_s2_vld     <= 1'b0;
            r_s2_addr    <= '0;
            r_s2_val     <= '0;
            r_fwd_vld    <= 1'b0;
            r_fwd_addr   <= '0;
            r_fwd_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);

            if ((r_state == S_IDLE) && start) begin
                r_count   <= num_updates;
                r_issued  <= '0;
                r_retired <= '0;
                r_changed <= '0;
            end else begin
                if (w_fifo_re) r_issued <= r_issued + CNT_W'(1);
                if (r_s2_vld) begin
                    r_retired <= r_retired + CNT_W'(1);
                    if ((w_new != w_old) && (r_changed != {CNT_W{1'b1}}))
                        r_changed <= r_changed + CNT_W'(1);
                end
            end

            r_s1_vld <= w_fifo_re;
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_addr <= w_s1_addr;
                r_s2_val  <= fifo_dout[DATA_W-1:0];
            end

            r_fwd_vld  <= r_s2_vld;
            r_fwd_addr <= r_s2_addr;
            r_fwd_data <= w_new;

            if (r_state == S_IDLE) r_host_rdata <= r_mem[host_addr];
        end
    end

    // Vertex storage is not reset; reads return pre-write data on a same-address collision.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
        r_rd_data <= r_mem[w_s1_addr];
    end

    assign fifo_re     = w_fifo_re;
    assign host_rdata  = r_host_rdata;
    assign busy        = r_busy;
    assign done        = r_done;
    assign changed_cnt = r_changed;

endmodule

// File: tb/tb_update_gather.sv
// Directed bench for update_gather with a queue-backed FIFO model and a readback scoreboard.
module tb_update_gather;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned UPD_W  = ADDR_W + DATA_W;
    localparam int unsigned CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  num_updates;
    logic              fifo_empty = 1'b1;
    logic              fifo_re;
    logic [UPD_W-1:0]  fifo_dout = '0;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  changed_cnt;

    logic [UPD_W-1:0]  fq[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model[16];
    int checks = 0;
    int errors = 0;
    int re_cnt = 0;
    int underflow = 0;
    int exp_changed = 0;

    update_gather #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .UPD_W(UPD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_updates(num_updates),
        .fifo_empty(fifo_empty), .fifo_re(fifo_re), .fifo_dout(fifo_dout),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .busy(busy), .done(done), .changed_cnt(changed_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: data valid the cycle after a read, registered empty flag.
    always @(posedge clk) begin
        if (fifo_re && fq.size() > 0) fifo_dout <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    always @(negedge clk) begin
        if (fifo_re) re_cnt++;
        if (fifo_re && fifo_empty) underflow++;
    end

    function automatic logic [DATA_W-1:0] op_f(input logic [DATA_W-1:0] old, input logic [DATA_W-1:0] val);
`ifdef GATHER_SUM_EN
        return old + val;
`else
        return (val < old) ? val : old;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input int a, input logic [DATA_W-1:0] d);
        host_we = 1'b1; host_addr = ADDR_W'(a); host_wdata = d;
        tick();
        host_we = 1'b0;
        model[a] = d;
    endtask

    task automatic host_rd(input int a, input string tag);
        exp_q.push_back(model[a]);
        host_addr = ADDR_W'(a);
        tick();
        chk(tag, 64'(host_rdata), 64'(exp_q.pop_front()));
    endtask

    task automatic push_rec(input int d, input logic [DATA_W-1:0] v, input bit apply);
        logic [DATA_W-1:0] nv;
        fq.push_back({ADDR_W'(d), v});
        if (apply) begin
            nv = op_f(model[d], v);
            if (nv != model[d]) exp_changed++;
            model[d] = nv;
        end
    endtask

    task automatic start_pass(input int n);
        num_updates = CNT_W'(n); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin seen = 1'b1; break; end
            tick();
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_changed"}, 64'(changed_cnt), 64'(exp_changed));
        tick();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int re0;
        int seen_re;
        rst = 1'b1; start = 1'b0; num_updates = '0;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_changed", 64'(changed_cnt), 64'd0);
        chk("rst_fifo_re", 64'(fifo_re), 64'd0);
        chk("rst_host_rdata", 64'(host_rdata), 64'd0);
        rst = 1'b0;

        for (int a = 0; a < 16; a++) host_wr(a, 32'd100);
        // Write and read the same address in one cycle: old data returns.
        host_we = 1'b1; host_addr = 10'd13; host_wdata = 32'd77;
        tick();
        host_we = 1'b0;
        chk("host_rw_same_old", 64'(host_rdata), 64'(model[13]));
        model[13] = 32'd77;
        host_rd(13, "host_rd13");

        // Pass 1: mixed improving / non-improving updates.
        exp_changed = 0;
        push_rec(2, 32'd40, 1); push_rec(5, 32'd200, 1); push_rec(7, 32'd100, 1);
        start_pass(3);
        wait_done("p1");
        host_rd(2, "p1_mem2"); host_rd(5, "p1_mem5"); host_rd(7, "p1_mem7");

        // Pass 2: back-to-back same destination exercises forwarding.
`ifdef GATHER_SUM_EN
        host_wr(3, 32'd1);
`else
        host_wr(3, 32'd50);
`endif
        exp_changed = 0;
        push_rec(3, 32'd30, 1); push_rec(3, 32'd20, 1); push_rec(3, 32'd25, 1);
        start_pass(3);
        wait_done("p2");
        host_rd(3, "p2_mem3");

        // Pass 3: FIFO holds more than the requested count.
        exp_changed = 0;
        for (int i = 0; i < 6; i++) push_rec(8 + i, 32'(50 + i), (i < 4));
        re0 = re_cnt;
        start_pass(4);
        wait_done("p3");
        chk("p3_re_pulses", 64'(re_cnt - re0), 64'd4);
        chk("p3_left_in_fifo", 64'(fq.size()), 64'd2);
        fq.delete();
        tick(); tick();
        for (int i = 0; i < 6; i++) host_rd(8 + i, "p3_mem");

        // Pass 4: zero updates -> done exactly two cycles after start.
        exp_changed = 0;
        re0 = re_cnt;
        num_updates = '0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("p4_busy", 64'(busy), 64'd1);
        chk("p4_done_early", 64'(done), 64'd0);
        tick();
        chk("p4_done", 64'(done), 64'd1);
        tick();
        chk("p4_done_clear", 64'(done), 64'd0);
        chk("p4_no_re", 64'(re_cnt - re0), 64'd0);

        // Pass 5: host write and a second start while busy are ignored; FIFO gaps.
        exp_changed = 0;
        start_pass(2);
        tick();
        host_we = 1'b1; host_addr = 10'd4; host_wdata = 32'd7;
        tick(); tick();
        host_we = 1'b0;
        num_updates = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        chk("p5_busy_waiting", 64'(busy), 64'd1);
        push_rec(6, 32'd10, 1);
        tick(); tick();
        push_rec(1, 32'd999, 1);
        wait_done("p5");
        host_rd(4, "p5_mem4_kept");
        host_rd(6, "p5_mem6");
        host_rd(1, "p5_mem1");

        // Pass 6: reset one cycle after the second pop.
        for (int i = 0; i < 5; i++) push_rec(8 + i, 32'd5, 0);
        for (int i = 0; i < 5; i++) host_wr(8 + i, 32'd100);
        start_pass(5);
        seen_re = 0;
        for (int i = 0; i < 50; i++) begin
            if (fifo_re) seen_re++;
            if (seen_re == 2) break;
            tick();
        end
        chk("p6_two_pops", 64'(seen_re), 64'd2);
        tick();
        rst = 1'b1;
        tick();
        chk("p6_rst_busy", 64'(busy), 64'd0);
        chk("p6_rst_fifo_re", 64'(fifo_re), 64'd0);
        chk("p6_rst_changed", 64'(changed_cnt), 64'd0);
        rst = 1'b0;
        fq.delete();
        tick(); tick();
        host_addr = 10'd8;
        tick();
        chk("p6_mem8_at_most_first",
            64'((host_rdata === 32'd100) || (host_rdata === op_f(32'd100, 32'd5))), 64'd1);
        for (int i = 1; i < 5; i++) host_rd(8 + i, "p6_mem_untouched");

        chk("no_underflow", 64'(underflow), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
